// File: rtl/capture_sequencer.sv
// capture_sequencer: sequences one ADC capture in the sample-clock domain.
// Flow: arm edge -> optional wait for inactive trigger -> pre-trigger samples -> armed
// (writing, waiting for trigger) -> capture to the sample limit -> one-cycle done.
// Optional feature macro CAPTURE_TIMEOUT_EN adds timeout_i/timed_out_o. These force a
// trigger after timeout_i cycles in ARMED. With the macro undefined, ARMED waits indefinitely.
module capture_sequencer #(
    parameter int unsigned CNT_W = 32,
    parameter int unsigned PRE_W = 16  // keep narrower than CNT_W so presamples+1 fits
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             arm_i,
    input  logic             trigger_i,
    input  logic             trigger_mode_i,
    input  logic             trigger_wait_i,
    input  logic             trigger_now_i,
    input  logic [CNT_W-1:0] maxsamples_i,
    input  logic [PRE_W-1:0] presamples_i,
    input  logic             sample_valid_i,
    input  logic             store_full_i,
`ifdef CAPTURE_TIMEOUT_EN
    input  logic [CNT_W-1:0] timeout_i,
    output logic             timed_out_o,
`endif
    output logic             armed_o,
    output logic             capture_go_o,
    output logic             sample_we_o,
    output logic [CNT_W-1:0] sample_count_o,
    output logic             done_o,
    output logic             overflow_o
);

    typedef enum logic [2:0] {
        StIdle,
        StWaitInactive,
        StPresample,
        StArmed,
        StCapture,
        StDone
    } state_e;

    state_e           state_q, state_d;
    logic             arm_q;
    logic [CNT_W-1:0] count_q, count_d;
    logic [CNT_W-1:0] limit_q, limit_d;
    logic [PRE_W-1:0] pre_q, pre_d;
    logic             ovf_q, ovf_d;

    logic             trig_act;
    logic             arm_rise;
    logic             force_trig;
    logic             sample_we;
    logic [CNT_W-1:0] max_eff;
    logic [CNT_W-1:0] pre_plus1;
    logic [CNT_W-1:0] new_limit;
    logic [CNT_W-1:0] pre_last;
    logic [CNT_W-1:0] cap_last;

    assign trig_act = (trigger_i == trigger_mode_i);
    assign arm_rise = arm_i & ~arm_q;

    // Capture limit derived from the live inputs; only latched on the arming edge.
    always_comb begin
        max_eff   = (maxsamples_i == '0) ? CNT_W'(1) : maxsamples_i;
        pre_plus1 = CNT_W'(presamples_i) + CNT_W'(1);
        new_limit = (max_eff > pre_plus1) ? max_eff : pre_plus1;
        pre_last  = CNT_W'(pre_q) - CNT_W'(1);
        cap_last  = limit_q - CNT_W'(1);
    end

`ifdef CAPTURE_TIMEOUT_EN
    logic [CNT_W-1:0] to_cnt_q, to_cnt_d;
    logic             timed_out_q, timed_out_d;

    assign force_trig = (state_q == StArmed) && (timeout_i != '0) && (to_cnt_q == timeout_i);

    // Timeout counter runs only in ARMED, so it restarts from zero on every entry.
    always_comb begin
        to_cnt_d    = '0;
        timed_out_d = timed_out_q;
        if (state_q == StArmed) begin
            to_cnt_d = (to_cnt_q != '1) ? to_cnt_q + CNT_W'(1) : to_cnt_q;
        end
        if (state_q == StIdle && arm_rise) begin
            timed_out_d = 1'b0;
        end else if (force_trig && state_d == StCapture) begin
            timed_out_d = 1'b1;
        end
    end

    // Timeout state registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            to_cnt_q    <= '0;
            timed_out_q <= 1'b0;
        end else begin
            to_cnt_q    <= to_cnt_d;
            timed_out_q <= timed_out_d;
        end
    end

    assign timed_out_o = timed_out_q;
`else
    assign force_trig = 1'b0;
`endif

    // Next-state, write strobe and counter update.
    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        limit_d   = limit_q;
        pre_d     = pre_q;
        ovf_d     = ovf_q;
        sample_we = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (arm_rise) begin
                    limit_d = new_limit;
                    pre_d   = presamples_i;
                    count_d = '0;
                    ovf_d   = 1'b0;
                    if (trigger_wait_i && trig_act) begin
                        state_d = StWaitInactive;
                    end else if (presamples_i != '0) begin
                        state_d = StPresample;
                    end else begin
                        state_d = StArmed;
                    end
                end
            end
            StWaitInactive: begin
                if (store_full_i) begin
                    state_d = StDone;
                    ovf_d   = 1'b1;
                end else if (!arm_i) begin
                    state_d = StIdle;
                end else if (!trig_act) begin
                    state_d = (pre_q != '0) ? StPresample : StArmed;
                end
            end
            StPresample: begin
                sample_we = sample_valid_i & ~store_full_i;
                if (store_full_i) begin
                    state_d = StDone;
                    ovf_d   = 1'b1;
                end else if (!arm_i) begin
                    state_d = StIdle;
                end else if (sample_we && count_q == pre_last) begin
                    state_d = StArmed;
                end
            end
            StArmed: begin
                sample_we = sample_valid_i & ~store_full_i;
                if (store_full_i) begin
                    state_d = StDone;
                    ovf_d   = 1'b1;
                end else if (!arm_i) begin
                    state_d = StIdle;
                end else if (trig_act || trigger_now_i || force_trig) begin
                    state_d = StCapture;
                end
            end
            StCapture: begin
                sample_we = sample_valid_i & ~store_full_i;
                if (store_full_i) begin
                    state_d = StDone;
                    ovf_d   = 1'b1;
                // >= also ends a capture whose armed phase already passed the limit
                end else if (sample_we && count_q >= cap_last) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        if (sample_we && count_q != '1) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            arm_q   <= 1'b0;
            count_q <= '0;
            limit_q <= '0;
            pre_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            arm_q   <= arm_i;
            count_q <= count_d;
            limit_q <= limit_d;
            pre_q   <= pre_d;
            ovf_q   <= ovf_d;
        end
    end

    assign armed_o        = (state_q == StWaitInactive) || (state_q == StPresample) ||
                            (state_q == StArmed);
    assign capture_go_o   = (state_q == StCapture);
    assign done_o         = (state_q == StDone);
    assign sample_we_o    = sample_we;
    assign sample_count_o = count_q;
    assign overflow_o     = ovf_q;

endmodule

// File: tb/tb_capture_sequencer.sv
// Self-checking bench for capture_sequencer. Expected values come from the capture
// rules: total writes equal max(maxsamples or 1, presamples + 1), trigger-to-go is one
// cycle, overflow ends the capture with the count frozen.
`timescale 1ns/1ps
module tb_capture_sequencer;
    localparam int unsigned CNT_W = 32;
    localparam int unsigned PRE_W = 16;

    logic             clk = 1'b0;
    logic             reset;
    logic             arm_i;
    logic             trigger_i;
    logic             trigger_mode_i;
    logic             trigger_wait_i;
    logic             trigger_now_i;
    logic [CNT_W-1:0] maxsamples_i;
    logic [PRE_W-1:0] presamples_i;
    logic             sample_valid_i;
    logic             store_full_i;
    logic             armed_o;
    logic             capture_go_o;
    logic             sample_we_o;
    logic [CNT_W-1:0] sample_count_o;
    logic             done_o;
    logic             overflow_o;
`ifdef CAPTURE_TIMEOUT_EN
    logic [CNT_W-1:0] timeout_i;
    logic             timed_out_o;
`endif

    capture_sequencer #(.CNT_W(CNT_W), .PRE_W(PRE_W)) dut (
        .clk            (clk),
        .reset          (reset),
        .arm_i          (arm_i),
        .trigger_i      (trigger_i),
        .trigger_mode_i (trigger_mode_i),
        .trigger_wait_i (trigger_wait_i),
        .trigger_now_i  (trigger_now_i),
        .maxsamples_i   (maxsamples_i),
        .presamples_i   (presamples_i),
        .sample_valid_i (sample_valid_i),
        .store_full_i   (store_full_i),
`ifdef CAPTURE_TIMEOUT_EN
        .timeout_i      (timeout_i),
        .timed_out_o    (timed_out_o),
`endif
        .armed_o        (armed_o),
        .capture_go_o   (capture_go_o),
        .sample_we_o    (sample_we_o),
        .sample_count_o (sample_count_o),
        .done_o         (done_o),
        .overflow_o     (overflow_o)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    int unsigned we_cnt = 0;
    int unsigned done_cnt = 0;

    // Count write strobes and done pulses mid-cycle, when inputs are stable.
    always @(negedge clk) begin
        if (sample_we_o === 1'b1) we_cnt <= we_cnt + 1;
        if (done_o === 1'b1) done_cnt <= done_cnt + 1;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout, required $finish");
        $fatal(1, "watchdog");
    end

    function automatic int unsigned exp_limit(input int unsigned m, input int unsigned p);
        int unsigned me;
        me = (m == 0) ? 1 : m;
        return (me > p + 1) ? me : p + 1;
    endfunction

    function automatic logic rnd_valid(input bit all);
        return all ? 1'b1 : logic'($urandom_range(0, 3) != 0);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic setup(input int unsigned m, input int unsigned p, input bit mode,
                         input bit wt);
        trigger_mode_i = mode;
        trigger_i      = ~mode;
        trigger_wait_i = wt;
        trigger_now_i  = 1'b0;
        maxsamples_i   = m;
        presamples_i   = PRE_W'(p);
        store_full_i   = 1'b0;
        sample_valid_i = 1'b0;
        arm_i          = 1'b0;
        tick();
        tick();
    endtask

    // Run cycles until done_o; on an expired budget, reset so later scenarios still run.
    task automatic wait_done(input bit all_valid, input bit toggle_arm, output bit got);
        got = 1'b0;
        for (int n = 0; n < 400; n++) begin
            if (done_o === 1'b1) begin
                got = 1'b1;
                break;
            end
            sample_valid_i = rnd_valid(all_valid);
            if (toggle_arm) arm_i = logic'($urandom_range(0, 1));
            tick();
        end
        if (!got) begin
            reset = 1'b1;
            arm_i = 1'b0;
            tick();
            reset = 1'b0;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        arm_i = 1'b0;
        trigger_i = 1'b0;
        trigger_mode_i = 1'b1;
        trigger_wait_i = 1'b0;
        trigger_now_i = 1'b0;
        maxsamples_i = '0;
        presamples_i = '0;
        sample_valid_i = 1'b1;
        store_full_i = 1'b0;
`ifdef CAPTURE_TIMEOUT_EN
        timeout_i = '0;
`endif
        tick();
        tick();
        n_cmp++; if (armed_o !== 1'b0) begin n_err++; $display("FAIL reset_armed got=%b exp=0", armed_o); end
        n_cmp++; if (capture_go_o !== 1'b0) begin n_err++; $display("FAIL reset_go got=%b exp=0", capture_go_o); end
        n_cmp++; if (sample_we_o !== 1'b0) begin n_err++; $display("FAIL reset_we got=%b exp=0", sample_we_o); end
        n_cmp++; if (sample_count_o !== '0) begin n_err++; $display("FAIL reset_count got=%0d exp=0", sample_count_o); end
        n_cmp++; if (done_o !== 1'b0) begin n_err++; $display("FAIL reset_done got=%b exp=0", done_o); end
        n_cmp++; if (overflow_o !== 1'b0) begin n_err++; $display("FAIL reset_ovf got=%b exp=0", overflow_o); end
        reset = 1'b0;
        sample_valid_i = 1'b0;
        tick();
    endtask

    // Trigger after a random armed delay; later iterations toggle arm_i during capture.
    task automatic test_basic();
        for (int it = 0; it < 8; it++) begin
            int unsigned m, d, lim, w0, d0;
            bit mode, all, got;
            m    = (it == 0) ? 8 : $urandom_range(3, 24);
            mode = (it == 0) ? 1'b1 : 1'($urandom_range(0, 1));
            d    = (it == 0) ? 4 : $urandom_range(0, m - 2);
            all  = (it == 0) || (it % 2 == 1);
            lim  = exp_limit(m, 0);
            setup(m, 0, mode, 1'b0);
            w0 = we_cnt;
            d0 = done_cnt;
            arm_i = 1'b1;
            tick();
            n_cmp++; if (armed_o !== 1'b1) begin n_err++; $display("FAIL basic_armed it=%0d got=%b exp=1", it, armed_o); end
            for (int k = 0; k < d; k++) begin
                sample_valid_i = rnd_valid(all);
                tick();
            end
            trigger_i = mode;
            sample_valid_i = rnd_valid(all);
            #1;
            n_cmp++; if (capture_go_o !== 1'b0) begin n_err++; $display("FAIL basic_go_early it=%0d got=%b exp=0", it, capture_go_o); end
            tick();
            n_cmp++; if (capture_go_o !== 1'b1) begin n_err++; $display("FAIL basic_go it=%0d got=%b exp=1", it, capture_go_o); end
            trigger_i = ~mode;
            wait_done(all, it >= 4, got);
            n_cmp++; if (got !== 1'b1) begin n_err++; $display("FAIL basic_done_seen it=%0d got=%b exp=1", it, got); end
            tick();
            n_cmp++; if (we_cnt - w0 !== lim) begin n_err++; $display("FAIL basic_writes it=%0d got=%0d exp=%0d", it, we_cnt - w0, lim); end
            n_cmp++; if (done_cnt - d0 !== 1) begin n_err++; $display("FAIL basic_done_pulses it=%0d got=%0d exp=1", it, done_cnt - d0); end
            n_cmp++; if (sample_count_o !== lim) begin n_err++; $display("FAIL basic_count it=%0d got=%0d exp=%0d", it, sample_count_o, lim); end
            n_cmp++; if (overflow_o !== 1'b0) begin n_err++; $display("FAIL basic_ovf it=%0d got=%b exp=0", it, overflow_o); end
        end
    endtask

    // Limit boundaries: maxsamples 0/1 and presamples exceeding maxsamples.
    task automatic test_limits();
        int unsigned ms[4] = '{0, 1, 3, 5};
        int unsigned ps[4] = '{0, 0, 6, 5};
        for (int it = 0; it < 4; it++) begin
            int unsigned lim, w0;
            bit got;
            lim = exp_limit(ms[it], ps[it]);
            setup(ms[it], ps[it], 1'b1, 1'b0);
            w0 = we_cnt;
            arm_i = 1'b1;
            tick();
            sample_valid_i = 1'b1;
            for (int k = 0; k < int'(ps[it]); k++) tick();
            sample_valid_i = 1'b0;
            trigger_i = 1'b1;
            tick();
            n_cmp++; if (capture_go_o !== 1'b1) begin n_err++; $display("FAIL limit_go it=%0d got=%b exp=1", it, capture_go_o); end
            trigger_i = 1'b0;
            wait_done(1'b1, 1'b0, got);
            tick();
            n_cmp++; if (we_cnt - w0 !== lim) begin n_err++; $display("FAIL limit_writes it=%0d got=%0d exp=%0d", it, we_cnt - w0, lim); end
            n_cmp++; if (sample_count_o !== lim) begin n_err++; $display("FAIL limit_count it=%0d got=%0d exp=%0d", it, sample_count_o, lim); end
        end
    endtask

    // Trigger held active through PRESAMPLE must not start the capture.
    task automatic test_presample();
        for (int it = 0; it < 4; it++) begin
            int unsigned p, m, lim, w0, d0, wr, guard;
            bit mode, got;
            p    = (it == 0) ? 4 : $urandom_range(1, 8);
            m    = (it == 0) ? 10 : $urandom_range(0, 20);
            mode = 1'($urandom_range(0, 1));
            lim  = exp_limit(m, p);
            setup(m, p, mode, 1'b0);
            w0 = we_cnt;
            d0 = done_cnt;
            trigger_i = mode;
            arm_i = 1'b1;
            tick();
            wr = 0;
            guard = 0;
            while (wr < p && guard < 200) begin
                sample_valid_i = rnd_valid(1'b0);
                #1;
                n_cmp++; if (capture_go_o !== 1'b0 || armed_o !== 1'b1) begin n_err++; $display("FAIL pre_ignore it=%0d got go=%b armed=%b exp go=0 armed=1", it, capture_go_o, armed_o); end
                n_cmp++; if (sample_we_o !== sample_valid_i) begin n_err++; $display("FAIL pre_we it=%0d got=%b exp=%b", it, sample_we_o, sample_valid_i); end
                tick();
                if (sample_valid_i) wr++;
                guard++;
            end
            sample_valid_i = 1'b0;
            #1;
            n_cmp++; if (capture_go_o !== 1'b0) begin n_err++; $display("FAIL pre_go_early it=%0d got=%b exp=0", it, capture_go_o); end
            tick();
            n_cmp++; if (capture_go_o !== 1'b1) begin n_err++; $display("FAIL pre_go it=%0d got=%b exp=1", it, capture_go_o); end
            trigger_i = ~mode;
            wait_done(1'b0, 1'b0, got);
            tick();
            n_cmp++; if (we_cnt - w0 !== lim) begin n_err++; $display("FAIL pre_writes it=%0d got=%0d exp=%0d", it, we_cnt - w0, lim); end
            n_cmp++; if (sample_count_o !== lim) begin n_err++; $display("FAIL pre_count it=%0d got=%0d exp=%0d", it, sample_count_o, lim); end
            n_cmp++; if (done_cnt - d0 !== 1) begin n_err++; $display("FAIL pre_done it=%0d got=%0d exp=1", it, done_cnt - d0); end
        end
    endtask

    task automatic test_wait_inactive();
        int unsigned w0, hold;
        bit mode, got;
        mode = 1'($urandom_range(0, 1));
        hold = $urandom_range(2, 6);
        setup(10, 0, mode, 1'b1);
        w0 = we_cnt;
        trigger_i = mode;
        arm_i = 1'b1;
        tick();
        for (int k = 0; k < int'(hold); k++) begin
            sample_valid_i = 1'b1;
            #1;
            n_cmp++; if (armed_o !== 1'b1 || capture_go_o !== 1'b0 || sample_we_o !== 1'b0) begin n_err++; $display("FAIL wait_hold k=%0d got armed=%b go=%b we=%b exp 1/0/0", k, armed_o, capture_go_o, sample_we_o); end
            tick();
        end
        trigger_i = ~mode;
        tick();
        tick();
        trigger_i = mode;
        #1;
        n_cmp++; if (capture_go_o !== 1'b0) begin n_err++; $display("FAIL wait_go_early got=%b exp=0", capture_go_o); end
        tick();
        n_cmp++; if (capture_go_o !== 1'b1) begin n_err++; $display("FAIL wait_go got=%b exp=1", capture_go_o); end
        trigger_i = ~mode;
        wait_done(1'b1, 1'b0, got);
        tick();
        n_cmp++; if (we_cnt - w0 !== 10) begin n_err++; $display("FAIL wait_writes got=%0d exp=10", we_cnt - w0); end
        // Without the wait option an already-active trigger fires at once.
        setup(5, 0, mode, 1'b0);
        trigger_i = mode;
        arm_i = 1'b1;
        tick();
        tick();
        n_cmp++; if (capture_go_o !== 1'b1) begin n_err++; $display("FAIL nowait_go got=%b exp=1", capture_go_o); end
        trigger_i = ~mode;
        wait_done(1'b1, 1'b0, got);
        tick();
    endtask

    task automatic test_overflow();
        for (int it = 0; it < 3; it++) begin
            int unsigned n, w0;
            n = (it == 0) ? 20 : $urandom_range(1, 40);
            setup(100, 0, 1'b1, 1'b0);
            w0 = we_cnt;
            arm_i = 1'b1;
            tick();
            n_cmp++; if (overflow_o !== 1'b0) begin n_err++; $display("FAIL ovf_cleared it=%0d got=%b exp=0", it, overflow_o); end
            trigger_i = 1'b1;
            tick();
            trigger_i = 1'b0;
            sample_valid_i = 1'b1;
            for (int k = 0; k < int'(n); k++) tick();
            store_full_i = 1'b1;
            #1;
            n_cmp++; if (sample_we_o !== 1'b0) begin n_err++; $display("FAIL ovf_we it=%0d got=%b exp=0", it, sample_we_o); end
            tick();
            store_full_i = 1'b0;
            n_cmp++; if (done_o !== 1'b1 || overflow_o !== 1'b1) begin n_err++; $display("FAIL ovf_done it=%0d got done=%b ovf=%b exp 1/1", it, done_o, overflow_o); end
            tick();
            n_cmp++; if (done_o !== 1'b0 || overflow_o !== 1'b1) begin n_err++; $display("FAIL ovf_sticky it=%0d got done=%b ovf=%b exp 0/1", it, done_o, overflow_o); end
            n_cmp++; if (sample_count_o !== n || we_cnt - w0 !== n) begin n_err++; $display("FAIL ovf_count it=%0d got count=%0d writes=%0d exp=%0d", it, sample_count_o, we_cnt - w0, n); end
        end
        // Full and trigger together in ARMED: full wins, no capture.
        setup(50, 0, 1'b1, 1'b0);
        arm_i = 1'b1;
        tick();
        trigger_i = 1'b1;
        store_full_i = 1'b1;
        tick();
        trigger_i = 1'b0;
        store_full_i = 1'b0;
        n_cmp++; if (done_o !== 1'b1 || capture_go_o !== 1'b0 || overflow_o !== 1'b1) begin n_err++; $display("FAIL ovf_armed got done=%b go=%b ovf=%b exp 1/0/1", done_o, capture_go_o, overflow_o); end
        tick();
    endtask

    task automatic test_abort_reset();
        int unsigned k, d0;
        setup(50, 0, 1'b1, 1'b0);
        d0 = done_cnt;
        k = $urandom_range(1, 6);
        arm_i = 1'b1;
        tick();
        sample_valid_i = 1'b1;
        for (int i = 0; i < int'(k); i++) tick();
        sample_valid_i = 1'b0;
        arm_i = 1'b0;
        tick();
        n_cmp++; if (armed_o !== 1'b0) begin n_err++; $display("FAIL abort_armed got=%b exp=0", armed_o); end
        sample_valid_i = 1'b1;
        trigger_i = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        n_cmp++; if (done_cnt - d0 !== 0) begin n_err++; $display("FAIL abort_done got=%0d exp=0", done_cnt - d0); end
        n_cmp++; if (sample_count_o !== k) begin n_err++; $display("FAIL abort_count got=%0d exp=%0d", sample_count_o, k); end
        // Re-arm, start capturing, then reset in the middle of it.
        trigger_i = 1'b0;
        sample_valid_i = 1'b0;
        arm_i = 1'b1;
        tick();
        n_cmp++; if (sample_count_o !== 0) begin n_err++; $display("FAIL rearm_count got=%0d exp=0", sample_count_o); end
        trigger_i = 1'b1;
        tick();
        trigger_i = 1'b0;
        sample_valid_i = 1'b1;
        tick();
        tick();
        tick();
        reset = 1'b1;
        tick();
        n_cmp++; if ({armed_o, capture_go_o, sample_we_o, done_o, overflow_o} !== 5'b0 || sample_count_o !== '0) begin n_err++; $display("FAIL midreset got armed=%b go=%b we=%b done=%b ovf=%b count=%0d exp all 0", armed_o, capture_go_o, sample_we_o, done_o, overflow_o, sample_count_o); end
        reset = 1'b0;
        arm_i = 1'b0;
        sample_valid_i = 1'b0;
        tick();
        tick();
        n_cmp++; if (done_cnt - d0 !== 0) begin n_err++; $display("FAIL midreset_done got=%0d exp=0", done_cnt - d0); end
    endtask

`ifdef CAPTURE_TIMEOUT_EN
    task automatic test_timeout();
        int unsigned first, w0;
        bit got;
        setup(60, 0, 1'b1, 1'b0);
        timeout_i = 50;
        w0 = we_cnt;
        arm_i = 1'b1;
        tick();
        n_cmp++; if (timed_out_o !== 1'b0) begin n_err++; $display("FAIL to_clear got=%b exp=0", timed_out_o); end
        first = 0;
        for (int k = 1; k <= 70 && first == 0; k++) begin
            tick();
            if (capture_go_o === 1'b1) first = k;
        end
        n_cmp++; if (first !== 51) begin n_err++; $display("FAIL to_latency got=%0d exp=51", first); end
        n_cmp++; if (timed_out_o !== 1'b1) begin n_err++; $display("FAIL to_flag got=%b exp=1", timed_out_o); end
        wait_done(1'b1, 1'b0, got);
        tick();
        n_cmp++; if (we_cnt - w0 !== 60) begin n_err++; $display("FAIL to_writes got=%0d exp=60", we_cnt - w0); end
        timeout_i = '0;
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_limits();
        test_presample();
        test_wait_inactive();
        test_overflow();
        test_abort_reset();
`ifdef CAPTURE_TIMEOUT_EN
        test_timeout();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
